// File: rtl/m_cpu_pkg.sv
// Shared constants and types for the CPU board top level: mode encoding,
// default timing parameters and the step counter width.
package m_cpu_pkg;

  localparam logic MODE_STEP = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  localparam int DB_CYCLES_DEFAULT = 500000;
  localparam int SLOW_DIV_DEFAULT  = 50000000;
  localparam int FAST_DIV_DEFAULT  = 5000000;

  localparam int STEP_CNT_W = 8;

  typedef enum logic {
    ST_STEP = MODE_STEP,
    ST_RUN  = MODE_RUN
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/m_step_ctrl_if.sv
// Button/switch inputs and CPU enable outputs of the step controller.
interface m_step_ctrl_if;
  import m_cpu_pkg::*;

  logic                  BTN_STEP;
  logic                  BTN_MODE;
  logic                  SPEED;
  logic                  CPU_EN;
  logic                  MODE;
  logic [STEP_CNT_W-1:0] STEP_CNT;

  modport master (
    output BTN_STEP, BTN_MODE, SPEED,
    input  CPU_EN, MODE, STEP_CNT
  );

  modport slave (
    input  BTN_STEP, BTN_MODE, SPEED,
    output CPU_EN, MODE, STEP_CNT
  );

endinterface

// File: rtl/m_debounce.sv
// Two-flop synchronizer, counting debouncer and press-edge detector for one
// active-low push-button; emits a one-cycle pulse on each debounced press.
module m_debounce #(
  parameter int DB_CYCLES = m_cpu_pkg::DB_CYCLES_DEFAULT
) (
  input  logic CLK1,
  input  logic RST,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_state_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          differ;
  logic          expire;

  assign differ = (sync2_reg != db_state_reg);
  assign expire = differ && (cnt_reg == CNT_LAST);

  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      db_state_reg <= 1'b1;
      cnt_reg      <= '0;
      press_reg    <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      // Only the released-to-pressed flip is an event; release is silent.
      press_reg <= expire && db_state_reg;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (expire) begin
        cnt_reg      <= '0;
        db_state_reg <= ~db_state_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/m_step_ctrl.sv
// CPU clock-enable generator: manual single-step or free-run at one of two
// prescaled rates, driven by debounced push-buttons.
module m_step_ctrl
  import m_cpu_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int SLOW_DIV  = SLOW_DIV_DEFAULT,
  parameter int FAST_DIV  = FAST_DIV_DEFAULT
) (
  input logic         CLK1,
  input logic         RST,
  m_step_ctrl_if.slave bus
);

  localparam int PW = $clog2(max_int(SLOW_DIV, FAST_DIV));
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_press;
  logic       step_ev;
  logic       mode_ev;

  assign btn_raw = {bus.BTN_MODE, bus.BTN_STEP};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      m_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .CLK1   (CLK1),
        .RST    (RST),
        .btn_raw(btn_raw[gi]),
        .press  (btn_press[gi])
      );
    end
  endgenerate

  assign step_ev = btn_press[0];
  assign mode_ev = btn_press[1];

  state_t                state_reg;
  state_t                state_next;
  logic [PW-1:0]         presc_reg;
  logic [PW-1:0]         presc_next;
  logic [PW-1:0]         div_last;
  logic                  cpu_en_reg;
  logic                  cpu_en_next;
  logic [STEP_CNT_W-1:0] step_cnt_reg;

  // SPEED is read live so a rate change applies on the very next compare.
  assign div_last = bus.SPEED ? FAST_LAST : SLOW_LAST;

  always_ff @(posedge CLK1 or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_STEP;
      presc_reg    <= '0;
      cpu_en_reg   <= 1'b0;
      step_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      cpu_en_reg   <= cpu_en_next;
      step_cnt_reg <= step_cnt_reg + STEP_CNT_W'(cpu_en_reg);
    end
  end

  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    cpu_en_next = 1'b0;
    case (state_reg)
      ST_STEP: begin
        // A mode press takes priority over a coincident step press.
        if (mode_ev) begin
          state_next = ST_RUN;
          presc_next = '0;
        end else if (step_ev) begin
          cpu_en_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (mode_ev) begin
          state_next = ST_STEP;
          presc_next = '0;
        end else if (presc_reg >= div_last) begin
          cpu_en_next = 1'b1;
          presc_next  = '0;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
    endcase
  end

  assign bus.CPU_EN   = cpu_en_reg;
  assign bus.MODE     = state_reg;
  assign bus.STEP_CNT = step_cnt_reg;

endmodule

// File: tb/tb_m_step_ctrl.sv
// Self-checking bench for m_step_ctrl: randomized button timing checked
// against pulse times predicted from the press-latency and run-period rules.
module tb_m_step_ctrl;
  import m_cpu_pkg::*;

  localparam int DB   = 4;
  localparam int SLOW = 10;
  localparam int FAST = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  m_step_ctrl_if bus ();

  m_step_ctrl #(
    .DB_CYCLES(DB),
    .SLOW_DIV (SLOW),
    .FAST_DIV (FAST)
  ) dut (
    .CLK1(clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   en_q[$];
  int   mode_edge = -1;
  logic mode_prev = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge index that starts every CPU_EN-high cycle and MODE rise.
  always @(negedge clk) begin
    if (!rst && bus.CPU_EN === 1'b1) en_q.push_back(cyc);
    if (bus.MODE === 1'b1 && mode_prev !== 1'b1) mode_edge = cyc;
    mode_prev = bus.MODE;
  end

  // Reference rules: a press first sampled at edge n yields CPU_EN (or the
  // MODE toggle) at edge n+DB+2; run pulses land every DIV edges after MODE.
  function automatic int exp_press_edge(input int n);
    return n + DB + 2;
  endfunction

  function automatic int exp_run_edge(input int m, input int k, input int div);
    return m + k * div;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.BTN_STEP = 1'b1;
    bus.BTN_MODE = 1'b1;
    bus.SPEED    = 1'b0;
    repeat (3) tick();
    en_q.delete();
    mode_edge = -1;
    rst = 1'b0;
    tick();
  endtask

  // sel: 0 = step, 1 = mode, 2 = both together
  task automatic press(input int sel, input int len, output int n);
    n = cyc + 1;
    if (sel != 1) bus.BTN_STEP = 1'b0;
    if (sel != 0) bus.BTN_MODE = 1'b0;
    repeat (len) tick();
    bus.BTN_STEP = 1'b1;
    bus.BTN_MODE = 1'b1;
    repeat (DB + 2) tick();
  endtask

  task automatic test_reset();
    bus.BTN_STEP = 1'b1;
    bus.BTN_MODE = 1'b1;
    bus.SPEED    = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    total_cnt++;
    if (bus.CPU_EN !== 1'b0) $display("FAIL reset_cpu_en: got %0b expected 0", bus.CPU_EN);
    else pass_cnt++;
    total_cnt++;
    if (bus.MODE !== MODE_STEP) $display("FAIL reset_mode: got %0b expected %0b", bus.MODE, MODE_STEP);
    else pass_cnt++;
    total_cnt++;
    if (bus.STEP_CNT !== 8'd0) $display("FAIL reset_step_cnt: got %0d expected 0", bus.STEP_CNT);
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_step_press();
    int n;
    int len;
    do_reset();
    len = $urandom_range(DB, 20);
    press(0, len, n);
    repeat (4) tick();
    $display("step press: hold=%0d first_edge=%0d pulses=%0d", len, n, en_q.size());
    total_cnt++;
    if (en_q.size() !== 1) $display("FAIL step_pulse_count: got %0d expected 1", en_q.size());
    else pass_cnt++;
    total_cnt++;
    if (en_q[0] !== exp_press_edge(n)) $display("FAIL step_latency: got edge %0d expected %0d", en_q[0], exp_press_edge(n));
    else pass_cnt++;
    total_cnt++;
    if (bus.STEP_CNT !== 8'd1) $display("FAIL step_cnt_one: got %0d expected 1", bus.STEP_CNT);
    else pass_cnt++;
    total_cnt++;
    if (bus.MODE !== MODE_STEP) $display("FAIL step_mode: got %0b expected %0b", bus.MODE, MODE_STEP);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    int len;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      len = $urandom_range(1, DB - 1);
      bus.BTN_STEP = 1'b0;
      repeat (len) tick();
      bus.BTN_STEP = 1'b1;
      repeat (3) tick();
    end
    repeat (DB + 4) tick();
    $display("glitch burst: pulses=%0d step_cnt=%0d", en_q.size(), bus.STEP_CNT);
    total_cnt++;
    if (en_q.size() !== 0) $display("FAIL glitch_pulses: got %0d expected 0", en_q.size());
    else pass_cnt++;
    total_cnt++;
    if (bus.STEP_CNT !== 8'd0) $display("FAIL glitch_step_cnt: got %0d expected 0", bus.STEP_CNT);
    else pass_cnt++;
  endtask

  task automatic test_run();
    int n;
    int m;
    do_reset();
    press(1, DB + $urandom_range(0, 4), n);
    m = exp_press_edge(n);
    total_cnt++;
    if (mode_edge !== m) $display("FAIL run_mode_latency: got edge %0d expected %0d", mode_edge, m);
    else pass_cnt++;
    fork
      begin
        int ns;
        for (int i = 0; i < 3; i++) press(0, $urandom_range(DB, DB + 3), ns);
      end
      begin
        for (int t = 0; t < 400 && en_q.size() < 26; t++) tick();
      end
    join
    $display("run slow: mode_edge=%0d pulses=%0d step_cnt=%0d", mode_edge, en_q.size(), bus.STEP_CNT);
    total_cnt++;
    if (en_q.size() !== 26) $display("FAIL run_pulse_count: got %0d expected 26", en_q.size());
    else pass_cnt++;
    for (int k = 0; k < 26; k++) begin
      total_cnt++;
      if (en_q[k] !== exp_run_edge(m, k + 1, SLOW))
        $display("FAIL run_period[%0d]: got edge %0d expected %0d", k, en_q[k], exp_run_edge(m, k + 1, SLOW));
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.STEP_CNT !== 8'd26) $display("FAIL run_step_cnt: got %0d expected 26", bus.STEP_CNT);
    else pass_cnt++;
    total_cnt++;
    if (bus.MODE !== MODE_RUN) $display("FAIL run_mode: got %0b expected %0b", bus.MODE, MODE_RUN);
    else pass_cnt++;
  endtask

  task automatic test_speed();
    int n;
    int m;
    int p;
    do_reset();
    press(1, DB, n);
    m = exp_press_edge(n);
    p = $urandom_range(4, 9);
    for (int t = 0; t < 40 && cyc < m + p; t++) tick();
    bus.SPEED = 1'b1;
    en_q.delete();
    repeat (9) tick();
    $display("speed switch: prescaler=%0d pulses=%0d", p, en_q.size());
    total_cnt++;
    if (en_q.size() !== 3) $display("FAIL speed_pulse_count: got %0d expected 3", en_q.size());
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      total_cnt++;
      if (en_q[k] !== m + p + 1 + k * FAST)
        $display("FAIL speed_edge[%0d]: got %0d expected %0d", k, en_q[k], m + p + 1 + k * FAST);
      else pass_cnt++;
    end
    bus.SPEED = 1'b0;
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    press(2, DB + $urandom_range(0, 3), n);
    $display("simultaneous press: mode_edge=%0d pulses=%0d", mode_edge, en_q.size());
    total_cnt++;
    if (mode_edge !== exp_press_edge(n)) $display("FAIL simul_mode_edge: got %0d expected %0d", mode_edge, exp_press_edge(n));
    else pass_cnt++;
    total_cnt++;
    if (bus.MODE !== MODE_RUN) $display("FAIL simul_mode: got %0b expected %0b", bus.MODE, MODE_RUN);
    else pass_cnt++;
    total_cnt++;
    if (en_q.size() !== 0) $display("FAIL simul_no_en: got %0d pulses expected 0", en_q.size());
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      press(0, $urandom_range(DB, DB + 2), n);
      if (i == 254) begin
        total_cnt++;
        if (bus.STEP_CNT !== 8'd255) $display("FAIL wrap_255: got %0d expected 255", bus.STEP_CNT);
        else pass_cnt++;
      end
    end
    $display("wrap: pulses=%0d step_cnt=%0d", en_q.size(), bus.STEP_CNT);
    total_cnt++;
    if (en_q.size() !== 256) $display("FAIL wrap_pulses: got %0d expected 256", en_q.size());
    else pass_cnt++;
    total_cnt++;
    if (en_q[255] !== exp_press_edge(n)) $display("FAIL wrap_last_edge: got %0d expected %0d", en_q[255], exp_press_edge(n));
    else pass_cnt++;
    total_cnt++;
    if (bus.STEP_CNT !== 8'd0) $display("FAIL wrap_zero: got %0d expected 0", bus.STEP_CNT);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    int m;
    do_reset();
    press(1, DB, n);
    m = exp_press_edge(n);
    for (int t = 0; t < 60 && cyc < m + 25; t++) tick();
    total_cnt++;
    if (bus.STEP_CNT !== 8'd2) $display("FAIL midrst_pre_cnt: got %0d expected 2", bus.STEP_CNT);
    else pass_cnt++;
    bus.BTN_STEP = 1'b0;
    repeat (2) tick();
    #1 rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.MODE !== MODE_STEP) $display("FAIL midrst_mode: got %0b expected %0b", bus.MODE, MODE_STEP);
    else pass_cnt++;
    total_cnt++;
    if (bus.CPU_EN !== 1'b0) $display("FAIL midrst_cpu_en: got %0b expected 0", bus.CPU_EN);
    else pass_cnt++;
    total_cnt++;
    if (bus.STEP_CNT !== 8'd0) $display("FAIL midrst_step_cnt: got %0d expected 0", bus.STEP_CNT);
    else pass_cnt++;
    en_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    n = cyc + 1;
    repeat (12) tick();
    bus.BTN_STEP = 1'b1;
    repeat (DB + 2) tick();
    $display("reset mid-run: post-release pulses=%0d", en_q.size());
    total_cnt++;
    if (en_q.size() !== 1) $display("FAIL midrst_pulse_count: got %0d expected 1", en_q.size());
    else pass_cnt++;
    total_cnt++;
    if (en_q[0] !== exp_press_edge(n)) $display("FAIL midrst_latency: got edge %0d expected %0d", en_q[0], exp_press_edge(n));
    else pass_cnt++;
    total_cnt++;
    if (bus.STEP_CNT !== 8'd1) $display("FAIL midrst_cnt_after: got %0d expected 1", bus.STEP_CNT);
    else pass_cnt++;
  endtask

  initial begin
    bus.BTN_STEP = 1'b1;
    bus.BTN_MODE = 1'b1;
    bus.SPEED    = 1'b0;
    test_reset();
    test_step_press();
    test_glitch();
    test_run();
    test_speed();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
